// File: rtl/id_pkg.sv
// Shared encodings and defaults for the decode-stage register file.
package id_pkg;

    // Immediate extension modes; 2'b11 aliases zero extension.
    typedef enum logic [1:0] {
        EXT_SIGN  = 2'b00,
        EXT_ZERO  = 2'b01,
        EXT_UPPER = 2'b10,
        EXT_ZERO2 = 2'b11
    } ext_mode_e;

    localparam int          REG_ZERO        = 0;
    localparam int          REG_SP          = 29;
    localparam logic [31:0] SP_INIT_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/id_imm_extender.sv
// Combinational 16-bit immediate extender (sign / zero / upper).
module id_imm_extender
    import id_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [15:0]       imm,
    input  logic [1:0]        ext_mode,
    output logic [DATA_W-1:0] extended_bits
);

    // Select the extension flavour; unknown/alias codes fall back to zero-extend.
    always_comb begin
        extended_bits = {{(DATA_W-16){1'b0}}, imm};
        case (ext_mode)
            EXT_SIGN:  extended_bits = {{(DATA_W-16){imm[15]}}, imm};
            EXT_UPPER: extended_bits = DATA_W'({imm, 16'h0000});
            default:   extended_bits = {{(DATA_W-16){1'b0}}, imm};
        endcase
    end

endmodule

// File: rtl/id_regfile_scoreboard.sv
// Decode-stage register file with write-to-read bypass, per-register
// pending-write scoreboard (RAW stall) and immediate extender.
module id_regfile_scoreboard
    import id_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 5,
    parameter int                CNT_W    = 2,
    parameter int                SP_INDEX = REG_SP,
    parameter logic [DATA_W-1:0] SP_INIT  = DATA_W'(SP_INIT_DEFAULT),
    parameter bit                BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instruction,
    input  logic [1:0]        ext_mode,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] write_register,
    input  logic [DATA_W-1:0] write_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_dest,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [DATA_W-1:0] extended_bits,
    output logic              stall
);

    localparam int              NREGS   = 2**ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NREGS-1:0][DATA_W-1:0] regs;
    logic [NREGS-1:0][CNT_W-1:0]  cnt;

    logic [ADDR_W-1:0] rs, rt;
    logic              wr_en, inc, dec;
    logic [NREGS-1:0]  inc_vec, dec_vec;
    logic [CNT_W-1:0]  eff_rs, eff_rt;
    logic              unused_opcode;

    assign rs = instruction[25:21+ADDR_W-5+0] ;
    assign rt = instruction[20:16];
    assign unused_opcode = &{1'b0, instruction[31:26]};

    assign wr_en = RegWrite && (write_register != '0);
    assign inc   = issue_valid && (issue_dest != '0);
    // An untracked writeback (count already 0) must not underflow.
    assign dec   = wr_en && (cnt[write_register] != '0);

    // Per-register increment/decrement strobes for the scoreboard.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 1; i < NREGS; i++) begin
            inc_vec[i] = inc && (issue_dest == ADDR_W'(i));
            dec_vec[i] = dec && (write_register == ADDR_W'(i));
        end
    end

    // Register array and pending counters; reset overrides write and issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= (i == SP_INDEX && i != REG_ZERO) ? SP_INIT : '0;
                cnt[i]  <= '0;
            end
        end else begin
            if (wr_en)
                regs[write_register] <= write_data;
            for (int i = 1; i < NREGS; i++) begin
                // Increment holds at full scale so a (illegal) issue during the
                // saturation stall cannot wrap the count to zero.
                if (inc_vec[i] && !dec_vec[i] && cnt[i] != CNT_MAX)
                    cnt[i] <= cnt[i] + 1'b1;
                else if (dec_vec[i] && !inc_vec[i])
                    cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    // Combinational reads with same-cycle writeback forwarding.
    always_comb begin
        read_data1 = regs[rs];
        read_data2 = regs[rt];
        if (BYPASS && wr_en && write_register == rs) read_data1 = write_data;
        if (BYPASS && wr_en && write_register == rt) read_data2 = write_data;
        if (rs == '0) read_data1 = '0;
        if (rt == '0) read_data2 = '0;
    end

    // Hazard detect: a writeback landing this cycle retires one pending write
    // early when bypass is on, since its data is already forwarded.
    always_comb begin
        eff_rs = cnt[rs];
        eff_rt = cnt[rt];
        if (BYPASS && dec && write_register == rs) eff_rs = cnt[rs] - 1'b1;
        if (BYPASS && dec && write_register == rt) eff_rt = cnt[rt] - 1'b1;
        stall = ((rs != '0) && (eff_rs != '0)) ||
                ((rt != '0) && (eff_rt != '0)) ||
                (issue_valid && (cnt[issue_dest] == CNT_MAX));
    end

    id_imm_extender #(.DATA_W(DATA_W)) u_ext (
        .imm           (instruction[15:0]),
        .ext_mode      (ext_mode),
        .extended_bits (extended_bits)
    );

endmodule

// File: tb/tb_id_regfile_scoreboard.sv
// Directed self-checking bench for id_regfile_scoreboard.
module tb_id_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic [1:0]  ext_mode;
    logic        RegWrite;
    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic        issue_valid;
    logic [4:0]  issue_dest;
    logic [31:0] read_data1, read_data2, extended_bits;
    logic        stall;

    int n_chk  = 0;
    int n_fail = 0;

    id_regfile_scoreboard dut (
        .clk            (clk),
        .reset          (reset),
        .instruction    (instruction),
        .ext_mode       (ext_mode),
        .RegWrite       (RegWrite),
        .write_register (write_register),
        .write_data     (write_data),
        .issue_valid    (issue_valid),
        .issue_dest     (issue_dest),
        .read_data1     (read_data1),
        .read_data2     (read_data2),
        .extended_bits  (extended_bits),
        .stall          (stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ins(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        instruction = {6'd0, rs, rt, imm};
    endtask

    task automatic idle();
        RegWrite = 1'b0; write_register = '0; write_data = '0;
        issue_valid = 1'b0; issue_dest = '0;
    endtask

    initial begin
        reset = 1'b1; ext_mode = 2'b00; idle(); set_ins(0, 0, 0);
        tick(); tick();
        reset = 1'b0;

        // reset state
        set_ins(29, 0, 0); #1;
        chk("rst_sp",    read_data1, 32'h8000_0000);
        chk("rst_r0",    read_data2, 32'h0);
        chk("rst_stall", {31'd0, stall}, 32'd0);

        // bypass then stored
        set_ins(8, 0, 0);
        RegWrite = 1; write_register = 8; write_data = 32'hDEAD_BEEF; #1;
        chk("byp_same",  read_data1, 32'hDEAD_BEEF);
        tick(); idle(); #1;
        chk("byp_next",  read_data1, 32'hDEAD_BEEF);

        // register 0
        set_ins(0, 0, 0);
        RegWrite = 1; write_register = 0; write_data = 32'h1234; #1;
        chk("r0_byp",    read_data1, 32'h0);
        tick(); idle(); #1;
        chk("r0_read",   read_data1, 32'h0);
        issue_valid = 1; issue_dest = 0; #1;
        chk("r0_iss",    {31'd0, stall}, 32'd0);
        tick(); idle(); #1;
        chk("r0_iss2",   {31'd0, stall}, 32'd0);

        // RAW on reg 5, cleared by bypassed writeback
        issue_valid = 1; issue_dest = 5; #1;
        chk("raw_pre",   {31'd0, stall}, 32'd0);
        tick(); idle(); set_ins(5, 0, 0); #1;
        chk("raw_stall", {31'd0, stall}, 32'd1);
        tick(); #1;
        chk("raw_hold",  {31'd0, stall}, 32'd1);
        RegWrite = 1; write_register = 5; write_data = 32'd7; #1;
        chk("raw_wb_st", {31'd0, stall}, 32'd0);
        chk("raw_wb_d",  read_data1, 32'd7);
        tick(); idle(); #1;
        chk("raw_after", {31'd0, stall}, 32'd0);
        chk("raw_aft_d", read_data1, 32'd7);

        // saturation on reg 9
        set_ins(0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            issue_valid = 1; issue_dest = 9; #1;
            chk("sat_iss",  {31'd0, stall}, 32'd0);
            tick();
        end
        issue_valid = 1; issue_dest = 9; #1;
        chk("sat_full",  {31'd0, stall}, 32'd1);
        idle(); set_ins(0, 9, 0); #1;
        chk("sat_rt",    {31'd0, stall}, 32'd1);
        set_ins(9, 0, 0);
        RegWrite = 1; write_register = 9; write_data = 32'h99; #1;
        chk("sat_wb1",   {31'd0, stall}, 32'd1);
        tick(); idle(); #1;
        chk("sat_cnt2",  {31'd0, stall}, 32'd1);
        issue_valid = 1; issue_dest = 9; #1;
        chk("sat_nofull",{31'd0, stall}, 32'd1);
        issue_valid = 0;
        RegWrite = 1; write_register = 9; write_data = 32'h9A; tick();
        // count 1 now; this writeback retires the last pending write
        #1;
        chk("sat_last",  {31'd0, stall}, 32'd0);
        tick(); idle(); #1;
        chk("sat_drain", {31'd0, stall}, 32'd0);
        chk("sat_data",  read_data1, 32'h9A);

        // extender
        set_ins(0, 0, 16'h8001);
        ext_mode = 2'b00; #1; chk("ext_sign",  extended_bits, 32'hFFFF_8001);
        ext_mode = 2'b01; #1; chk("ext_zero",  extended_bits, 32'h0000_8001);
        ext_mode = 2'b10; #1; chk("ext_upper", extended_bits, 32'h8001_0000);
        ext_mode = 2'b11; #1; chk("ext_zero2", extended_bits, 32'h0000_8001);
        set_ins(0, 0, 16'h7FFE);
        ext_mode = 2'b00; #1; chk("ext_pos",   extended_bits, 32'h0000_7FFE);

        // reset with reg 5 pending and reg 3 = 42
        issue_valid = 1; issue_dest = 5;
        RegWrite = 1; write_register = 3; write_data = 32'd42;
        tick(); idle(); set_ins(5, 3, 0); #1;
        chk("pre_rst_st", {31'd0, stall}, 32'd1);
        chk("pre_rst_r3", read_data2, 32'd42);
        reset = 1;
        issue_valid = 1; issue_dest = 7;
        RegWrite = 1; write_register = 3; write_data = 32'd99;
        tick(); reset = 0; idle(); #1;
        chk("rst2_stall", {31'd0, stall}, 32'd0);
        chk("rst2_r3",    read_data2, 32'd0);
        set_ins(7, 29, 0); #1;
        chk("rst2_r7",    {31'd0, stall}, 32'd0);
        chk("rst2_sp",    read_data2, 32'h8000_0000);
        // untracked writeback after reset: updates data, no underflow
        set_ins(5, 0, 0);
        RegWrite = 1; write_register = 5; write_data = 32'd11;
        tick(); idle(); #1;
        chk("post_rst_d", read_data1, 32'd11);
        chk("post_rst_s", {31'd0, stall}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
